// File: rtl/adder_tree_pkg.sv
// Shared types and helpers for the adder-tree accumulator slice.
// Optional build macro used by the consumers: ADDER_TREE_ACC_SAT_EN.
package adder_tree_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      ACCUM = 1'b1
   } acc_state_e;

   // Per-result side information carried next to the total in the result FIFO.
   typedef struct packed {
      logic sigma;
      logic sat;
   } result_tag_t;

   // Widest accumulator the sign-extension helper supports.
   localparam int SEXT_W = 64;

   // Sign-extend the low in_w bits of raw to SEXT_W bits; callers truncate to their width.
   function automatic logic signed [SEXT_W-1:0] sext_to_acc(
      input logic [SEXT_W-1:0] raw,
      input int unsigned       in_w
   );
      logic signed [SEXT_W-1:0] t;
      t = $signed(raw << (SEXT_W - in_w));
      return t >>> (SEXT_W - in_w);
   endfunction

endpackage

// File: rtl/acc_result_fifo.sv
// Synchronous FIFO for completed accumulator results; pointers carry an extra
// wrap bit so full and empty are distinguished without a counter.
module acc_result_fifo #(
   parameter int  DEPTH   = 2,
   parameter type entry_t = logic
) (
   input  logic   clk,
   input  logic   rst,
   input  logic   push,
   input  entry_t push_data,
   input  logic   pop,
   output entry_t pop_data,
   output logic   full,
   output logic   empty
);

   localparam int AW = $clog2(DEPTH);

   entry_t        mem [DEPTH];
   logic [AW:0]   wr_ptr;
   logic [AW:0]   rd_ptr;
   logic          do_push;
   logic          do_pop;

   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

   // A pop frees the head slot in the same cycle, so a full FIFO still accepts a push.
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
         if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
   end

   assign pop_data = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/adder_tree_accumulator.sv
// Accumulates signed adder-tree sums per vector and queues finished totals.
// Define ADDER_TREE_ACC_SAT_EN for saturating accumulation with a sat flag.
module adder_tree_accumulator
   import adder_tree_pkg::*;
#(
   parameter int IN_WIDTH   = 11,
   parameter int ACC_WIDTH  = 32,
   parameter int FIFO_DEPTH = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [IN_WIDTH-1:0]  sum_i,
   input  logic                 start_i,
   input  logic                 final_flag_i,
   input  logic                 sigma_tag_i,
   output logic [ACC_WIDTH-1:0] result_o,
   output logic                 result_sigma_o,
   output logic                 result_sat_o,
   output logic                 result_valid_o,
   input  logic                 result_ready_i,
   output logic                 busy_o,
   output logic                 overrun_o
);

   typedef struct packed {
      logic signed [ACC_WIDTH-1:0] total;
      result_tag_t                 tag;
   } entry_t;

   // Returns {clip, sum}; clip is only ever set in the saturating build.
   function automatic logic [ACC_WIDTH:0] acc_add(
      input logic signed [ACC_WIDTH-1:0] a,
      input logic signed [ACC_WIDTH-1:0] b
   );
`ifdef ADDER_TREE_ACC_SAT_EN
      logic [ACC_WIDTH:0] wide;
      wide = {a[ACC_WIDTH-1], a} + {b[ACC_WIDTH-1], b};
      if (wide[ACC_WIDTH] != wide[ACC_WIDTH-1])
         return {1'b1, wide[ACC_WIDTH], {(ACC_WIDTH-1){~wide[ACC_WIDTH]}}};
      return {1'b0, wide[ACC_WIDTH-1:0]};
`else
      return {1'b0, a + b};
`endif
   endfunction

   acc_state_e                  state;
   acc_state_e                  state_nxt;
   logic signed [ACC_WIDTH-1:0] acc;
   logic signed [ACC_WIDTH-1:0] acc_nxt;
   logic                        tag_r;
   logic                        tag_nxt;
   logic                        sat_r;
   logic                        sat_nxt;

   logic signed [ACC_WIDTH-1:0] sum_ext;
   logic signed [ACC_WIDTH-1:0] base;
   logic signed [ACC_WIDTH-1:0] add_val;
   logic                        base_sat;
   logic                        clip;
   logic                        push_req;
   entry_t                      push_entry;

   logic                        fifo_full;
   logic                        fifo_empty;
   logic                        do_pop;
   entry_t                      head;

   assign sum_ext = ACC_WIDTH'(sext_to_acc(SEXT_W'($unsigned(sum_i)), IN_WIDTH));

   always_comb begin
      state_nxt  = state;
      acc_nxt    = acc;
      tag_nxt    = tag_r;
      sat_nxt    = sat_r;
      push_req   = 1'b0;
      push_entry = '0;
      // In IDLE the first beat starts from zero with a clean sat flag.
      base       = (state == ACCUM) ? acc   : '0;
      base_sat   = (state == ACCUM) ? sat_r : 1'b0;
      {clip, add_val} = acc_add(base, sum_ext);
      if (start_i) begin
         if (final_flag_i) begin
            push_req             = 1'b1;
            push_entry.total     = add_val;
            push_entry.tag.sigma = (state == ACCUM) ? tag_r : sigma_tag_i;
            push_entry.tag.sat   = base_sat | clip;
            acc_nxt              = '0;
            sat_nxt              = 1'b0;
            state_nxt            = IDLE;
         end else begin
            acc_nxt   = add_val;
            sat_nxt   = base_sat | clip;
            state_nxt = ACCUM;
            if (state == IDLE) tag_nxt = sigma_tag_i;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         acc       <= '0;
         tag_r     <= 1'b0;
         sat_r     <= 1'b0;
         overrun_o <= 1'b0;
      end else begin
         state <= state_nxt;
         acc   <= acc_nxt;
         tag_r <= tag_nxt;
         sat_r <= sat_nxt;
         if (push_req && fifo_full && !do_pop) overrun_o <= 1'b1;
      end
   end

   assign do_pop = result_valid_o && result_ready_i;

   acc_result_fifo #(
      .DEPTH   (FIFO_DEPTH),
      .entry_t (entry_t)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push_req),
      .push_data (push_entry),
      .pop       (do_pop),
      .pop_data  (head),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   // Head fields are forced to zero whenever nothing is queued.
   assign result_valid_o = !fifo_empty;
   assign result_o       = result_valid_o ? head.total     : '0;
   assign result_sigma_o = result_valid_o ? head.tag.sigma : 1'b0;
   assign result_sat_o   = result_valid_o ? head.tag.sat   : 1'b0;
   assign busy_o         = (state == ACCUM);

endmodule
